// File: rtl/dp_vec_loader.sv
// N-channel vector loader: streams element tuples into NUM_CH lockstep banks behind a shared 1-cycle read port.
// Define DP_LOADER_ZERO_PAD_EN to zero-fill the unused tail of every bank after a short load.
module dp_vec_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH:0]          len,
  input  logic                         abort,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH:0]          count,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

`ifdef DP_LOADER_ZERO_PAD_EN
  typedef enum logic [1:0] {IDLE, LOAD, ZERO} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD} state_t;
`endif

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH:0]     target;
  logic [DATA_WIDTH-1:0]   bank [NUM_CH][DEPTH];
  logic                    handshake;
  logic                    last_elem;
  logic                    wr_zero;
  logic                    wr_en;

  // abort must suppress the handshake in the same cycle it is raised
  assign in_ready  = (state == LOAD) && !abort;
  assign handshake = in_valid && in_ready;
  assign last_elem = ({1'b0, wr_ptr} == (target - 1'b1));

`ifdef DP_LOADER_ZERO_PAD_EN
  assign wr_zero = (state == ZERO) && !abort;
`else
  assign wr_zero = 1'b0;
`endif

  assign wr_en = rst_n && (handshake || wr_zero);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      target <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            wr_ptr <= '0;
            count  <= '0;
            if (len == '0) begin
              target <= '0;
              done   <= 1'b1;
            end else begin
              target <= (len > DEPTH_CNT) ? DEPTH_CNT : len;
              state  <= LOAD;
              busy   <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
            if (last_elem) begin
`ifdef DP_LOADER_ZERO_PAD_EN
              if (target < DEPTH_CNT) begin
                state <= ZERO;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
`else
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef DP_LOADER_ZERO_PAD_EN
        // count keeps reporting target while the tail is cleared
        ZERO: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_ADDR) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // bank storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bank[c][wr_ptr] <= wr_zero ? '0 : in_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // reads sample the pre-write contents, so a same-edge collision returns old data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        for (int c = 0; c < NUM_CH; c++) begin
          rd_data[c*DATA_WIDTH +: DATA_WIDTH] <=
            ({1'b0, rd_addr} < DEPTH_CNT) ? bank[c][rd_addr] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dp_vec_loader.sv
// Scoreboard bench for dp_vec_loader: a bank model predicts read data, queued at issue and popped on rd_valid.
// Expectations follow DP_LOADER_ZERO_PAD_EN when the macro is defined for the build.
module tb_dp_vec_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  len;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        busy;
  logic        done;
  logic [5:0]  count;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_a [32];
  logic [7:0]  model_b [32];
  logic [15:0] sbq [$];

  dp_vec_loader #(
    .DATA_WIDTH(8),
    .NUM_CH(2),
    .DEPTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .len(len),
    .abort(abort),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .busy(busy),
    .done(done),
    .count(count),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // every rd_valid cycle must match the oldest outstanding prediction
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sbq.size() == 0) begin
        checkOutput("rd_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        checkOutput("rd_data", 32'(rd_data), 32'(sbq.pop_front()));
      end
    end
  end

  task automatic readBank(input int addr);
    logic [15:0] exp_val;
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = 5'(addr);
    exp_val = {model_b[addr], model_a[addr]};
    sbq.push_back(exp_val);
    @(negedge clk);
    rd_en = 1'b0;
    checkOutput("rd_valid", 32'(rd_valid), 32'd1);
    @(negedge clk);
    checkOutput("rd_valid_low", 32'(rd_valid), 32'd0);
    checkOutput("rd_hold", 32'(rd_data), 32'(exp_val));
  endtask

  int last_count = 0;

  // one load: valid pattern repeats every vlen cycles; abort_at is the 1-based valid element that carries abort
  task automatic applyStimulus(input int ln, input logic [15:0] vpat, input int vlen,
                               input int abort_at, input int collide_at,
                               input logic [7:0] a_base, input logic [7:0] a_step,
                               input logic [7:0] b_base, input logic [7:0] b_step);
    int tgt, accepted, cyc, lat, exp_lat;
    bit aborted, col_pending, hs;
    logic [7:0] da, db;
    tgt = (ln > 32) ? 32 : ln;
    @(negedge clk);
    start = 1'b1;
    len   = 6'(ln);
    @(negedge clk);
    start = 1'b0;
    if (tgt == 0) begin
      checkOutput("done_len0", 32'(done), 32'd1);
      checkOutput("busy_len0", 32'(busy), 32'd0);
      checkOutput("count_len0", 32'(count), 32'd0);
      last_count = 0;
      @(negedge clk);
      checkOutput("done_len0_pulse", 32'(done), 32'd0);
      return;
    end
    checkOutput("busy_start", 32'(busy), 32'd1);
    checkOutput("count_start", 32'(count), 32'd0);
    accepted = 0;
    aborted = 1'b0;
    col_pending = 1'b0;
    cyc = 0;
    while (!aborted && accepted < tgt && cyc < 200) begin
      in_valid = vpat[cyc % vlen];
      da = 8'(int'(a_base) + int'(a_step) * accepted);
      db = 8'(int'(b_base) + int'(b_step) * accepted);
      in_data = {db, da};
      start = (cyc == 1);
      len = 6'd1;
      abort = in_valid && (abort_at == accepted + 1);
      hs = in_valid && !abort;
      rd_en = 1'b0;
      if (col_pending) begin
        rd_en = 1'b1;
        rd_addr = 5'(collide_at);
        sbq.push_back({model_b[collide_at], model_a[collide_at]});
        col_pending = 1'b0;
      end else if (hs && collide_at == accepted) begin
        rd_en = 1'b1;
        rd_addr = 5'(accepted);
        sbq.push_back({model_b[accepted], model_a[accepted]});
        col_pending = 1'b1;
      end
      #1;
      checkOutput("in_ready", 32'(in_ready), 32'(!abort));
      if (hs) begin
        model_a[accepted] = da;
        model_b[accepted] = db;
        accepted++;
      end
      if (abort) aborted = 1'b1;
      cyc++;
      @(negedge clk);
      in_valid = 1'b0;
      abort = 1'b0;
      start = 1'b0;
      rd_en = 1'b0;
      if (!aborted && accepted < tgt) begin
        checkOutput("busy_load", 32'(busy), 32'd1);
        checkOutput("done_early", 32'(done), 32'd0);
        checkOutput("count_load", 32'(count), 32'(accepted));
      end
    end
    if (!aborted && accepted < tgt) checkOutput("load_timeout", 32'(accepted), 32'(tgt));
    if (aborted) begin
      checkOutput("busy_abort", 32'(busy), 32'd0);
      checkOutput("done_abort", 32'(done), 32'd0);
      checkOutput("count_abort", 32'(count), 32'(accepted));
      last_count = accepted;
      @(negedge clk);
      checkOutput("done_abort_late", 32'(done), 32'd0);
      return;
    end
`ifdef DP_LOADER_ZERO_PAD_EN
    exp_lat = (tgt < 32) ? (32 - tgt + 1) : 1;
    for (int i = tgt; i < 32; i++) begin
      model_a[i] = 8'h00;
      model_b[i] = 8'h00;
    end
`else
    exp_lat = 1;
`endif
    lat = 1;
    while (!done && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("done_latency", 32'(lat), 32'(exp_lat));
    checkOutput("busy_end", 32'(busy), 32'd0);
    checkOutput("count_end", 32'(count), 32'(tgt));
    last_count = tgt;
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    rd_en = 1'b0;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;

    $display("[TB] full load of 32 tuples (i, 2i)");
    applyStimulus(32, 16'h0001, 1, -1, -1, 8'd0, 8'd1, 8'd0, 8'd2);
    readBank(5);
    readBank(0);
    readBank(31);

    $display("[TB] gapped valid, start while busy");
    applyStimulus(4, 16'b0000000001011001, 7, -1, -1, 8'h40, 8'd1, 8'h80, 8'd1);
    for (int i = 0; i < 5; i++) readBank(i);

    $display("[TB] abort with third element");
    applyStimulus(8, 16'h0001, 1, 3, -1, 8'hA0, 8'd1, 8'hB0, 8'd1);
    for (int i = 0; i < 3; i++) readBank(i);

    $display("[TB] abort in idle beats start");
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    len = 6'd5;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("idle_abort_busy", 32'(busy), 32'd0);
    checkOutput("idle_abort_done", 32'(done), 32'd0);
    checkOutput("idle_abort_count", 32'(count), 32'(last_count));

    $display("[TB] zero length");
    applyStimulus(0, 16'h0001, 1, -1, -1, 8'h00, 8'd0, 8'h00, 8'd0);
    readBank(0);

    $display("[TB] len 40 clamps to depth");
    applyStimulus(40, 16'h0001, 1, -1, -1, 8'h20, 8'd1, 8'h60, 8'd3);
    readBank(31);
    readBank(0);
    repeat (2) @(negedge clk);
    checkOutput("clamp_idle_busy", 32'(busy), 32'd0);

    $display("[TB] preload 0xFF then short load of 3");
    applyStimulus(32, 16'h0001, 1, -1, -1, 8'hFF, 8'd0, 8'hFF, 8'd0);
    applyStimulus(3, 16'h0001, 1, -1, -1, 8'd1, 8'd1, 8'd1, 8'd1);
    for (int i = 0; i < 32; i++) readBank(i);

    $display("[TB] read/write collision at addr 4");
    applyStimulus(8, 16'h0001, 1, -1, -1, 8'h0D, 8'd1, 8'h0D, 8'd1);
    applyStimulus(8, 16'h0001, 1, -1, 4, 8'h1E, 8'd1, 8'h1E, 8'd1);
    readBank(4);

    $display("[TB] reset during a load");
    @(negedge clk);
    start = 1'b1;
    len = 6'd8;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h5A5A;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
